// File: rtl/dlx_pipe_pkg.sv
// Shared DLX pipeline definitions: stage payload widths, IF/ID field offsets
// and the bubble (NOP) payload for every stage boundary.
package dlx_pipe_pkg;

    localparam int IFID_W  = 83;
    localparam int IDEX_W  = 150;
    localparam int EXMEM_W = 110;
    localparam int MEMWB_W = 75;

    // IF/ID payload layout
    localparam int IFID_NPC_LO     = 0;
    localparam int IFID_NPC_HI     = 31;
    localparam int IFID_INSTR_LO   = 32;
    localparam int IFID_INSTR_HI   = 63;
    localparam int IFID_PCTOREG    = 64;
    localparam int IFID_REGTOPC    = 65;
    localparam int IFID_JUMP       = 66;
    localparam int IFID_BRANCH     = 67;
    localparam int IFID_BRZERO     = 68;
    localparam int IFID_RTYPE      = 69;
    localparam int IFID_REGWRITE   = 70;
    localparam int IFID_MEMTOREG   = 71;
    localparam int IFID_MEMWRITE   = 72;
    localparam int IFID_LOADSIGN   = 73;
    localparam int IFID_MUL        = 74;
    localparam int IFID_EXTOP      = 75;
    localparam int IFID_LHIOP      = 76;
    localparam int IFID_DSIZE_LO   = 77;
    localparam int IFID_DSIZE_HI   = 78;
    localparam int IFID_ALUCTRL_LO = 79;
    localparam int IFID_ALUCTRL_HI = 82;

    // A bubble carries no asserted control bits at any stage
    localparam logic [IFID_W-1:0]  IFID_NOP  = '0;
    localparam logic [IDEX_W-1:0]  IDEX_NOP  = '0;
    localparam logic [EXMEM_W-1:0] EXMEM_NOP = '0;
    localparam logic [MEMWB_W-1:0] MEMWB_NOP = '0;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating stall-cycle counter with synchronous clear (clear wins over count).
module pipe_stall_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised DLX pipeline-stage register with valid/ready, flush and stall counter.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import dlx_pipe_pkg::*;
#(
    parameter int               WIDTH     = IFID_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;
    logic             w_drain;

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_valid & out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

`ifdef PIPE_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_in_ready;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_skid_valid_nxt;
    logic [WIDTH-1:0] w_skid_data_nxt;

    // Ready comes straight from a flop, so out_ready never reaches in_ready
    assign in_ready = r_in_ready;

    always_comb begin
        w_valid_nxt      = r_valid;
        w_data_nxt       = r_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (flush) begin
            w_valid_nxt      = 1'b0;
            w_data_nxt       = NOP_VALUE;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = NOP_VALUE;
        end else if (r_skid_valid) begin
            if (w_drain) begin
                w_valid_nxt      = 1'b1;
                w_data_nxt       = r_skid_data;
                w_skid_valid_nxt = 1'b0;
                w_skid_data_nxt  = NOP_VALUE;
            end
        end else if (w_accept) begin
            // Main is stalled: park the new payload behind it to keep order
            if (r_valid && !out_ready) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = in_data;
            end else begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = in_data;
            end
        end else if (w_drain) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_data       <= NOP_VALUE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= NOP_VALUE;
            r_in_ready   <= 1'b0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_data       <= w_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
        end
    end
`else
    assign in_ready = ~r_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end
    end
`endif

    pipe_stall_ctr #(
        .CNT_W (CNT_W)
    ) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (r_valid & ~out_ready),
        .i_clr (clr_stats),
        .o_cnt (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register for the DLX pipeline, the generalised successor of the fixed 83-bit IF/ID stage. It holds one payload (PC+4, instruction and decoded control bits) per stage boundary, with valid/ready flow control, flush (squash to bubble) and a stall-cycle counter. The same block is instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB, with WIDTH and NOP_VALUE set per stage.

Parameters:
WIDTH, 83, payload width in bits
NOP_VALUE, {WIDTH{1'b0}}, payload driven while the stage holds a bubble (all control bits deasserted)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  input  1  stage clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds a live payload
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  registered payload; NOP_VALUE when out_valid=0
flush  input  1  squash held and incoming payload (taken branch/jump)
clr_stats  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0: out_valid=0, out_data=NOP_VALUE, stall_cnt=0, skid empty. in_ready resolves to 1 combinationally, or 1 from the first clk edge after release when PIPE_SKID_EN is defined.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Latency: 1 cycle. A payload accepted at edge N appears on out_data/out_valid after edge N.
- Base mode: in_ready = ~out_valid | out_ready (combinational pass-through of ready).
- Next-state priority, highest first:
  1. flush: out_valid<=0, out_data<=NOP_VALUE, skid cleared. A concurrent accept is discarded. in_ready is unaffected by flush.
  2. Accept: out_data<=in_data, out_valid<=1.
  3. Drain without accept: out_valid<=0, out_data<=NOP_VALUE.
  4. Otherwise hold. While out_valid=1 and out_ready=0, out_data must stay stable.
- Simultaneous accept and drain: the new payload replaces the old one with no bubble, giving full throughput.
- stall_cnt: increments when out_valid & ~out_ready and saturates at 2^CNT_W-1 (no wrap). clr_stats takes priority and loads 0 that cycle. Flush does not clear it.
- Reset asserted mid-stall: the payload is lost and the outputs take their reset values immediately (asynchronously).

Optional Feature:
PIPE_SKID_EN.
- Defined: a 2-entry skid buffer (main + skid). in_ready = ~skid_valid, registered, so there is no combinational ready path from out_ready to in_ready.
  - An accept while the main register is stalled (valid and ~out_ready) goes to skid.
  - On drain, skid moves to main, and in_ready rises the next cycle.
  - Accept + drain with skid empty loads main directly.
  - Flush clears both entries.
  - Order is preserved and latency stays 1 cycle when not stalled.
- Undefined: single register with combinational in_ready, as specified in Behaviour.

Decomposition:
- Package dlx_pipe_pkg holds:
  - stage widths: IFID_W=83 and the other stage widths
  - IF/ID field offsets: NPC 0..31, INSTR 32..63, PCTOREG 64, REGTOPC 65, JUMP 66, BRANCH 67, BRZERO 68, RTYPE 69, REGWRITE 70, MEMTOREG 71, MEMWRITE 72, LOADSIGN 73, MUL 74, EXTOP 75, LHIOP 76, DSIZE 77..78, ALUCTRL 79..82
  - the per-stage NOP constants
- One sub-module, pipe_stall_ctr (saturating counter with clear), is a natural split. The skid logic stays inline under the macro.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_data=all-ones -> out_valid=0, out_data=NOP_VALUE, stall_cnt=0. After release, the first accept appears 1 cycle later.
- Streaming: out_ready=1, in_valid=1, in_data=0,1,2,3 on consecutive cycles -> out_data 0,1,2,3 on the next four cycles, out_valid constant 1, no bubbles.
- Stall: load 0xA5, then out_ready=0 for 5 cycles with in_valid=1 and in_data=0x3C -> out_data holds 0xA5, stall_cnt=5. Base mode: in_ready=0 throughout. Skid mode: 0x3C is captured into skid, then in_ready=0. With out_ready=1, 0xA5 then 0x3C are delivered in order.
- Flush: stage holds 0x11 and in_valid=1 with 0x22, assert flush for 1 cycle -> next cycle out_valid=0 and out_data=NOP_VALUE; 0x22 is not delivered.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=15. Pulse clr_stats while still stalled -> 0 that cycle, then counting resumes from 1.
- Reset mid-operation: drop rst_n for a half-cycle during a stall with skid full -> outputs go to reset values asynchronously, and both entries are empty after release.
